// File: rtl/pmem_pkg.sv
// Shared constants and FSM state type for the physical-memory line responder.
package pmem_pkg;
  localparam int LINE_BITS     = 256;
  localparam int BEAT_BITS     = 64;
  localparam int BEATS         = 4;
  localparam int OFFSET_BITS   = 5;
  localparam int BEAT_IDX_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } pmem_state_t;
endpackage

// File: rtl/pmem_responder_line_store_ram.sv
// Single-port 64-bit backing store, synchronous write and registered read.
module line_store_ram
  import pmem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [ADDR_BITS+BEAT_IDX_BITS-1:0] addr,
  input  logic [BEAT_BITS-1:0]               wdata,
  output logic [BEAT_BITS-1:0]               rdata
);
  localparam int DEPTH = BEATS << ADDR_BITS;

  logic [BEAT_BITS-1:0] mem_r [DEPTH];
  logic [BEAT_BITS-1:0] rdata_r;

  // Storage array with read-before-write registered output.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/pmem_responder.sv
// Line-memory responder: accepts one 256-bit line read/write, waits LATENCY
// cycles, moves the line through the RAM in four beats and pulses pmem_resp.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_resp,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 proto_err
);
  localparam int RAM_AW = ADDR_BITS + BEAT_IDX_BITS;

  pmem_state_t                  state_r;
  logic [7:0]                   wait_cnt_r;
  logic [BEAT_IDX_BITS-1:0]     beat_r;
  logic [ADDR_BITS-1:0]         index_r;
  logic [LINE_BITS-1:0]         wdata_r;
  logic                         is_write_r;
  logic                         pmem_resp_r;
  logic                         proto_err_r;
  logic [LINE_BITS-1:0]         rdata_r;

  logic [BEAT_IDX_BITS-1:0]     beat_next_s;
  logic                         ram_we_s;
  logic [RAM_AW-1:0]            ram_addr_s;
  logic [BEAT_BITS-1:0]         ram_wdata_s;
  logic [BEAT_BITS-1:0]         ram_rdata_s;
  logic                         unused_addr_s;

  assign unused_addr_s = ^{pmem_address[OFFSET_BITS-1:0],
                           pmem_address[31:OFFSET_BITS+ADDR_BITS]};
  assign beat_next_s   = beat_r + 2'd1;
  assign ram_wdata_s   = wdata_r[{beat_r, 6'd0} +: BEAT_BITS];

  // RAM port control; reads are issued one beat ahead of capture.
  always_comb begin
    ram_we_s   = 1'b0;
    ram_addr_s = {index_r, beat_r};
    case (state_r)
      WAIT: begin
        ram_addr_s = {index_r, 2'd0};
      end
      XFER: begin
        if (is_write_r) begin
          ram_we_s   = 1'b1;
          ram_addr_s = {index_r, beat_r};
        end else begin
          ram_addr_s = {index_r, beat_next_s};
        end
      end
      default: begin
        ram_addr_s = {index_r, beat_r};
      end
    endcase
  end

  // Request FSM with latency counter, beat counter, latches and line assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 8'd0;
      beat_r      <= 2'd0;
      index_r     <= '0;
      wdata_r     <= '0;
      is_write_r  <= 1'b0;
      pmem_resp_r <= 1'b0;
      proto_err_r <= 1'b0;
      rdata_r     <= '0;
    end else begin
      pmem_resp_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            index_r    <= pmem_address[OFFSET_BITS +: ADDR_BITS];
            wdata_r    <= pmem_wdata;
            is_write_r <= pmem_write;
            wait_cnt_r <= 8'(LATENCY - 1);
            state_r    <= WAIT;
            if (pmem_read && pmem_write) begin
              proto_err_r <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_r == 8'd0) begin
            state_r <= XFER;
            beat_r  <= 2'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r - 8'd1;
          end
        end
        XFER: begin
          if (!is_write_r) begin
            rdata_r[{beat_r, 6'd0} +: BEAT_BITS] <= ram_rdata_s;
          end
          if (beat_r == 2'd3) begin
            state_r     <= RESP;
            pmem_resp_r <= 1'b1;
          end
          beat_r <= beat_next_s;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  line_store_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  assign pmem_resp  = pmem_resp_r;
  assign pmem_rdata = rdata_r;
  assign proto_err  = proto_err_r;
endmodule
